regfile_dump: RTL and testbench

//   Debug read-out engine for the 32x32 MIPS register file.
//   On start, reads registers 0..NUM_REGS-1 in order through one regfile read-select port.

---
 rtl/regfile_dump.sv | 92 +++++++++
 tb/tb_regfile_dump.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks register indices 0..NUM_REGS-1 through one
// regfile read port and streams (index, value) pairs on a valid/ready output.
module regfile_dump #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_sel,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        state
);

    // Output handshake: a pair transfers on a rising edge where out_valid and
    // out_ready are both 1; once raised, out_valid and the pair stay stable
    // until that transfer, except when abort or reset drops them.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] idx;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    state_d = SEND;
            SEND:    if (out_ready) state_d = (idx == LAST_IDX) ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // abort outranks everything, including a start in the same cycle
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            state_q <= state_d;
            if (abort) begin
                idx       <= '0;
                out_valid <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: idx <= '0;
                    READ: begin
                        out_data  <= rd_data;
                        out_idx   <= idx;
                        out_valid <= 1'b1;
                    end
                    SEND: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            // index saturates at the last register; DONE clears it
                            if (idx != LAST_IDX) idx <= idx + ADDR_W'(1);
                        end
                    end
                    DONE: idx <= '0;
                    default: idx <= '0;
                endcase
            end
        end
    end

    assign busy   = (state_q == READ) || (state_q == SEND);
    assign done   = (state_q == DONE);
    assign rd_sel = (state_q == READ) ? idx : '0;
    assign state  = state_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: behavioural regfile, handshake monitor,
// expected-value queue per dump, and a single summary line.
module tb_regfile_dump;
  logic        clk = 1'b0;
  logic        reset, start, abort, out_ready;
  logic        busy, done, out_valid;
  logic [4:0]  rd_sel, out_idx;
  logic [31:0] rd_data, out_data;
  logic [1:0]  state;

  logic [31:0] regs [32];
  logic [31:0] exp_q [$];
  logic [4:0]  rec_idx [$];
  logic [31:0] rec_data [$];
  int          hs_cyc [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb rd_data = regs[rd_sel];

  regfile_dump #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .rd_sel(rd_sel), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .state(state)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // monitor: handshakes, done pulses, pair stability under backpressure
  logic        prev_hold = 1'b0;
  logic [4:0]  prev_idx;
  logic [31:0] prev_data;
  always @(negedge clk) begin
    if (prev_hold) begin
      check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
      check_eq("hold_idx", {27'd0, out_idx}, {27'd0, prev_idx});
      check_eq("hold_data", out_data, prev_data);
    end
    prev_hold = out_valid && !out_ready && !abort && !reset;
    prev_idx  = out_idx;
    prev_data = out_data;
    if (out_valid && out_ready && !abort && !reset) begin
      rec_idx.push_back(out_idx);
      rec_data.push_back(out_data);
      hs_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_regs();
    for (int k = 0; k < 32; k++) regs[k] = 32'(k) * 32'h01010101;
  endtask

  task automatic load_exp();
    exp_q.delete();
    for (int k = 0; k < 32; k++) exp_q.push_back(32'(k) * 32'h01010101);
  endtask

  task automatic clear_rec();
    rec_idx.delete();
    rec_data.delete();
    hs_cyc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // rand_rdy: 30% ready duty; extra: spurious start pulses mid-dump
  task automatic wait_done(input string tag, input bit rand_rdy, input bit extra, output int n);
    n = 0;
    while (!done && n < 3000) begin
      if (rand_rdy) out_ready = ($urandom_range(0, 9) < 3);
      if (extra) start = (n % 13 == 5);
      tick();
      n++;
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic check_dump(input string tag);
    check_eq({tag, "_count"}, rec_idx.size(), 32'd32);
    for (int i = 0; i < 32 && i < rec_idx.size(); i++) begin
      check_eq($sformatf("%s_idx%0d", tag, i), {27'd0, rec_idx[i]}, i);
      check_eq($sformatf("%s_data%0d", tag, i), rec_data[i], exp_q[i]);
    end
  endtask

  int n;
  int d0;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    fill_regs();

    // 1: reset with random inputs
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom_range(0, 1));
      abort = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_idx", {27'd0, out_idx}, 32'd0);
    check_eq("rst_data", out_data, 32'd0);
    check_eq("rst_sel", {27'd0, rd_sel}, 32'd0);
    check_eq("rst_state", {30'd0, state}, 32'd0);
    reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    tick();

    // 2: full dump, ready tied high
    load_exp(); clear_rec();
    pulse_start();
    check_eq("t2_busy_read", {31'd0, busy}, 32'd1);
    wait_done("t2", 1'b0, 1'b0, n);
    check_eq("t2_latency", n, 32'd64);
    check_eq("t2_busy_in_done", {31'd0, busy}, 32'd0);
    tick();
    check_eq("t2_done_one_cycle", {31'd0, done}, 32'd0);
    check_dump("t2");
    for (int i = 1; i < hs_cyc.size(); i++)
      check_eq($sformatf("t2_gap%0d", i), hs_cyc[i] - hs_cyc[i-1], 32'd2);

    // 3: backpressure
    load_exp(); clear_rec();
    pulse_start();
    wait_done("t3", 1'b1, 1'b0, n);
    out_ready = 1'b1;
    tick();
    check_dump("t3");

    // 4: abort in the 5th SEND cycle with ready low
    out_ready = 1'b0; clear_rec(); d0 = done_cnt;
    pulse_start();
    n = 0;
    for (int i = 0; i < 20 && n < 5; i++) begin
      tick();
      if (out_valid) n++;
    end
    check_eq("t4_send_cycles", n, 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("t4_valid", {31'd0, out_valid}, 32'd0);
    check_eq("t4_busy", {31'd0, busy}, 32'd0);
    check_eq("t4_state", {30'd0, state}, 32'd0);
    repeat (4) tick();
    check_eq("t4_no_done", done_cnt - d0, 32'd0);
    check_eq("t4_no_pairs", rec_idx.size(), 32'd0);
    out_ready = 1'b1; load_exp(); clear_rec();
    pulse_start();
    wait_done("t4r", 1'b0, 1'b0, n);
    tick();
    check_dump("t4r");

    // 5: spurious starts while busy
    load_exp(); clear_rec(); d0 = done_cnt;
    pulse_start();
    wait_done("t5", 1'b0, 1'b1, n);
    repeat (4) tick();
    check_eq("t5_one_done", done_cnt - d0, 32'd1);
    check_eq("t5_idle", {31'd0, busy}, 32'd0);
    check_dump("t5");

    // 6: reset during READ of idx 10
    clear_rec();
    pulse_start();
    n = 0;
    while (!(state == 2'd1 && rd_sel == 5'd10) && n < 200) begin
      tick();
      n++;
    end
    check_eq("t6_reached_r10", {27'd0, rd_sel}, 32'd10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t6_state", {30'd0, state}, 32'd0);
    check_eq("t6_valid", {31'd0, out_valid}, 32'd0);
    check_eq("t6_idx", {27'd0, out_idx}, 32'd0);
    check_eq("t6_data", out_data, 32'd0);
    check_eq("t6_busy", {31'd0, busy}, 32'd0);
    load_exp(); clear_rec();
    pulse_start();
    wait_done("t6r", 1'b0, 1'b0, n);
    tick();
    check_dump("t6r");

    // 7: write r7 before its READ -> new value
    load_exp(); exp_q[7] = 32'hA5A5_0007; clear_rec();
    pulse_start();
    n = 0;
    while (!(state == 2'd1 && rd_sel == 5'd3) && n < 200) begin
      tick();
      n++;
    end
    regs[7] = 32'hA5A5_0007;
    wait_done("t7", 1'b0, 1'b0, n);
    tick();
    check_dump("t7");

    // 8: write r7 after its READ -> old value
    exp_q.delete();
    for (int k = 0; k < 32; k++) exp_q.push_back(regs[k]);
    clear_rec();
    pulse_start();
    n = 0;
    while (!(out_valid && out_idx == 5'd9) && n < 200) begin
      tick();
      n++;
    end
    regs[7] = 32'h5A5A_7777;
    wait_done("t8", 1'b0, 1'b0, n);
    tick();
    check_dump("t8");

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
